// File: rtl/im_pkg.sv
// Shared instruction-memory definitions.
// Used by the loader and by the instruction memory itself.
package im_pkg;

  localparam int IM_DEPTH  = 256;
  localparam int IM_ADDR_W = 8;
  localparam int IM_WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    LAST,
    DONE
  } im_ld_state_t;

endpackage

// File: rtl/im_word_packer.sv
// Big-endian byte-to-word packer.
// The first byte of a word lands in bits 31:24.
module im_word_packer
  import im_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  idx_q, idx_d;
  logic [31:0] pack_q, pack_d;

  // The word completes on byte 3; it is formed from the live byte.
  always_comb begin
    word       = pack_q;
    word[7:0]  = byte_data;
    word_valid = byte_valid && (idx_q == 2'd3);
  end

  // Route the accepted byte into its field.
  always_comb begin
    idx_d  = idx_q;
    pack_d = pack_q;
    if (clear) begin
      idx_d  = 2'd0;
      pack_d = '0;
    end else if (byte_valid) begin
      idx_d = idx_q + 2'd1;
      unique case (idx_q)
        2'd0: pack_d[31:24] = byte_data;
        2'd1: pack_d[23:16] = byte_data;
        2'd2: pack_d[15:8]  = byte_data;
        2'd3: pack_d[7:0]   = byte_data;
      endcase
    end
  end

  // Byte index and partial-word register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= 2'd0;
      pack_q <= '0;
    end else begin
      idx_q  <= idx_d;
      pack_q <= pack_d;
    end
  end

endmodule

// File: rtl/im_loader.sv
// Instruction-memory loader: byte stream in, word writes out.
// Keeps the core in reset until the full image is written.
module im_loader
  import im_pkg::*;
#(
  parameter int DEPTH  = IM_DEPTH,
  parameter int ADDR_W = IM_ADDR_W,
  parameter int WORD_W = IM_WORD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   load_len,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic              cpu_hold,
  output logic              done,
  output logic [ADDR_W:0]   word_cnt
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  im_ld_state_t state_q, state_d;

  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [WORD_W-1:0] wr_data_q, wr_data_d;
  logic              hold_q, hold_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  len_q, len_d;

  logic        accept;
  logic        clear;
  logic        word_valid;
  logic [31:0] word;

  // Abort wins over a byte offered in the same cycle.
  always_comb begin
    in_ready = (state_q == LOAD) && !abort;
    accept   = in_valid && in_ready;
  end

  im_word_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .byte_valid (accept),
    .byte_data  (in_data),
    .word_valid (word_valid),
    .word       (word)
  );

  // Next-state and registered-output decode.
  always_comb begin
    state_d   = state_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    hold_d    = hold_q;
    done_d    = done_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    clear     = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          clear = 1'b1;
          len_d = load_len;
          cnt_d = '0;
          if (load_len == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end else begin
            state_d = LOAD;
            done_d  = 1'b0;
            hold_d  = 1'b1;
          end
        end
      end
      LOAD: begin
        if (abort) begin
          state_d = IDLE;
          clear   = 1'b1;
        end else if (word_valid) begin
          wr_en_d   = 1'b1;
          wr_addr_d = cnt_q[ADDR_W-1:0];
          wr_data_d = word;
          cnt_d     = cnt_q + 1'b1;
          if (cnt_q == len_q - 1'b1)
            state_d = LAST;
        end
      end
      LAST: begin
        if (abort) begin
          state_d = IDLE;
          clear   = 1'b1;
        end else begin
          state_d = DONE;
          done_d  = 1'b1;
          hold_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      hold_q    <= 1'b1;
      done_q    <= 1'b0;
      cnt_q     <= '0;
      len_q     <= '0;
    end else begin
      state_q   <= state_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      hold_q    <= hold_d;
      done_q    <= done_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign cpu_hold = hold_q;
  assign done     = done_q;
  assign word_cnt = cnt_q;

endmodule
